// File: rtl/m_axis_rc_adapt_x4_if.sv
// m_axis_rc_adapt_x4_if: core-side and user-side RC AXIS signals of the x4 adapter
interface m_axis_rc_adapt_x4_if #(
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 75
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 32;
  localparam int UKEEP_WIDTH = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] m_axis_rc_tdata;
  logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep;
  logic m_axis_rc_tlast;
  logic [USER_WIDTH-1:0] m_axis_rc_tuser;
  logic m_axis_rc_tvalid;
  logic [3:0] m_axis_rc_tready;
  logic [DATA_WIDTH-1:0] m_axis_rc_tdata_a;
  logic [UKEEP_WIDTH-1:0] m_axis_rc_tkeep_a;
  logic m_axis_rc_tlast_a;
  logic [USER_WIDTH-1:0] m_axis_rc_tuser_a;
  logic m_axis_rc_tvalid_a;
  logic m_axis_rc_tready_a;
  modport slave (
    input m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tuser,
    input m_axis_rc_tvalid, m_axis_rc_tready_a,
    output m_axis_rc_tready, m_axis_rc_tdata_a, m_axis_rc_tkeep_a, m_axis_rc_tlast_a,
    output m_axis_rc_tuser_a, m_axis_rc_tvalid_a
  );
  modport master (
    output m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tuser,
    output m_axis_rc_tvalid, m_axis_rc_tready_a,
    input m_axis_rc_tready, m_axis_rc_tdata_a, m_axis_rc_tkeep_a, m_axis_rc_tlast_a,
    input m_axis_rc_tuser_a, m_axis_rc_tvalid_a
  );
endinterface

// File: rtl/m_axis_rc_adapt_x4.sv
// m_axis_rc_adapt_x4: FWFT-buffered RC completion adapter with byte keep, packet count and discontinue flag
module m_axis_rc_adapt_x4 #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 32,
  parameter int UKEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 75,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        user_clk,
  input  logic        user_reset_n,
  m_axis_rc_adapt_x4_if.slave rc,
  output logic [15:0] rc_pkt_count,
  output logic        rc_discontinue_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [UKEEP_WIDTH-1:0] keep_mem [FIFO_DEPTH];
  logic last_mem [FIFO_DEPTH];
  logic [USER_WIDTH-1:0] user_mem [FIFO_DEPTH];
  logic [UKEEP_WIDTH-1:0] keep_x;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic rdy_q, push, pop, valid;
  genvar i;
  for (i = 0; i < KEEP_WIDTH; i++) begin : g_keep
    assign keep_x[4*i +: 4] = {4{rc.m_axis_rc_tkeep[i]}};
  end
  assign valid = count != '0;
  assign push = rc.m_axis_rc_tvalid & rdy_q;
  assign pop = valid & rc.m_axis_rc_tready_a;
  assign rc.m_axis_rc_tready = {4{rdy_q}};
  assign rc.m_axis_rc_tvalid_a = valid;
  assign rc.m_axis_rc_tdata_a = data_mem[rd_ptr];
  assign rc.m_axis_rc_tkeep_a = keep_mem[rd_ptr];
  assign rc.m_axis_rc_tuser_a = user_mem[rd_ptr];
  assign rc.m_axis_rc_tlast_a = valid & last_mem[rd_ptr];
  // occupancy after this edge; push and pop together leave it unchanged
  always_comb begin
    count_next = (push & ~pop) ? count + CW'(1) : (pop & ~push) ? count - CW'(1) : count;
  end
  // storage array needs no reset: unread entries are never shown as valid
  always_ff @(posedge user_clk) begin
    if (push) begin
      data_mem[wr_ptr] <= rc.m_axis_rc_tdata;
      keep_mem[wr_ptr] <= keep_x;
      last_mem[wr_ptr] <= rc.m_axis_rc_tlast;
      user_mem[wr_ptr] <= rc.m_axis_rc_tuser;
    end
  end
  // pointers, occupancy, registered core ready and statistics
  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rdy_q <= 1'b0;
      rc_pkt_count <= '0;
      rc_discontinue_err <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count_next;
      rdy_q <= count_next != CW'(FIFO_DEPTH);
      rc_pkt_count <= (pop & last_mem[rd_ptr]) ? rc_pkt_count + 16'd1 : rc_pkt_count;
      rc_discontinue_err <= rc_discontinue_err | (push & rc.m_axis_rc_tuser[42]);
    end
  end
endmodule

// File: tb/tb_m_axis_rc_adapt_x4.sv
// tb_m_axis_rc_adapt_x4: directed table and sequence checks of the RC adapter
module tb_m_axis_rc_adapt_x4;
  typedef struct {
    logic [127:0] data;
    logic [3:0] keep;
    logic last;
    logic [74:0] user;
    logic [15:0] kexp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [127:0] tdata;
  logic [3:0] tkeep;
  logic tlast, tvalid, tready_a;
  logic [74:0] tuser;
  logic [15:0] pkt, exp_pkt;
  logic err;
  int total = 0, bad = 0;
  int sent, rcv, nb, base;
  vec_t v[6];
  m_axis_rc_adapt_x4_if bus ();
  assign bus.m_axis_rc_tdata = tdata;
  assign bus.m_axis_rc_tkeep = tkeep;
  assign bus.m_axis_rc_tlast = tlast;
  assign bus.m_axis_rc_tuser = tuser;
  assign bus.m_axis_rc_tvalid = tvalid;
  assign bus.m_axis_rc_tready_a = tready_a;
  m_axis_rc_adapt_x4 dut (
    .user_clk(clk),
    .user_reset_n(rst_n),
    .rc(bus.slave),
    .rc_pkt_count(pkt),
    .rc_discontinue_err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc();
    logic wp, rp;
    tvalid = sent < nb;
    tdata = 128'(base + sent);
    tlast = sent == nb - 1;
    tuser = '0;
    tkeep = 4'hF;
    wp = tvalid & bus.m_axis_rc_tready[0];
    rp = bus.m_axis_rc_tvalid_a & tready_a;
    if (rp) begin
      chk("order", bus.m_axis_rc_tdata_a, 128'(base + rcv));
      if (rcv == nb - 1) exp_pkt++;
      rcv++;
    end
    step();
    if (wp) sent++;
  endtask
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    v[0] = '{128'h0123456789abcdef_fedcba9876543210, 4'b0111, 1'b1, 75'h1234, 16'h0FFF};
    v[1] = '{128'h11111111_22222222_33333333_44444444, 4'b1111, 1'b0, 75'h5, 16'hFFFF};
    v[2] = '{128'hdeadbeef_cafef00d_0badc0de_feedface, 4'b0000, 1'b1, 75'h0, 16'h0000};
    v[3] = '{128'ha5a5a5a5_5a5a5a5a_a5a5a5a5_5a5a5a5a, 4'b1010, 1'b1, 75'h7ff, 16'hF0F0};
    v[4] = '{128'h0, 4'b0101, 1'b0, 75'h3_0000_0000_0000_0000, 16'h0F0F};
    v[5] = '{{4{32'h600d_1dea}}, 4'b1000, 1'b1, 75'h1, 16'hF000};
    rst_n = 1'b0;
    tvalid = 1'b0;
    tready_a = 1'b0;
    tdata = '0;
    tkeep = '0;
    tlast = 1'b0;
    tuser = '0;
    exp_pkt = '0;
    repeat (3) step();
    chk("rst_tready", 128'(bus.m_axis_rc_tready), 128'h0);
    chk("rst_tvalid_a", 128'(bus.m_axis_rc_tvalid_a), 128'h0);
    chk("rst_tlast_a", 128'(bus.m_axis_rc_tlast_a), 128'h0);
    chk("rst_pkt", 128'(pkt), 128'h0);
    chk("rst_err", 128'(err), 128'h0);
    rst_n = 1'b1;
    step();
    chk("rel_tready", 128'(bus.m_axis_rc_tready), 128'hF);
    chk("rel_tvalid_a", 128'(bus.m_axis_rc_tvalid_a), 128'h0);
    tready_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tdata = v[k].data;
      tkeep = v[k].keep;
      tlast = v[k].last;
      tuser = v[k].user;
      tvalid = 1'b1;
      step();
      tvalid = 1'b0;
      chk("vec_tvalid_a", 128'(bus.m_axis_rc_tvalid_a), 128'h1);
      chk("vec_tdata_a", bus.m_axis_rc_tdata_a, v[k].data);
      chk("vec_tkeep_a", 128'(bus.m_axis_rc_tkeep_a), 128'(v[k].kexp));
      chk("vec_tlast_a", 128'(bus.m_axis_rc_tlast_a), 128'(v[k].last));
      chk("vec_tuser_a", 128'(bus.m_axis_rc_tuser_a), 128'(v[k].user));
      step();
      if (v[k].last) exp_pkt++;
      chk("vec_pkt", 128'(pkt), 128'(exp_pkt));
      chk("vec_empty", 128'(bus.m_axis_rc_tvalid_a), 128'h0);
    end
    sent = 0; rcv = 0; nb = 6; base = 32'h1000;
    tready_a = 1'b0;
    repeat (8) cyc();
    chk("bp_accepted", 128'(sent), 128'd4);
    chk("bp_tready", 128'(bus.m_axis_rc_tready), 128'h0);
    chk("bp_tvalid_a", 128'(bus.m_axis_rc_tvalid_a), 128'h1);
    tready_a = 1'b1;
    for (int c = 0; c < 40 && rcv < nb; c++) cyc();
    tvalid = 1'b0;
    chk("bp_received", 128'(rcv), 128'd6);
    chk("bp_drained", 128'(bus.m_axis_rc_tvalid_a), 128'h0);
    chk("bp_pkt", 128'(pkt), 128'(exp_pkt));
    tkeep = 4'hF;
    tuser = '0;
    for (int k = 0; k < 100; k++) begin
      tvalid = 1'b1;
      tdata = {4{32'h3000 + k}};
      tlast = k == 99;
      step();
      chk("fr_tready", 128'(bus.m_axis_rc_tready), 128'hF);
      chk("fr_tvalid_a", 128'(bus.m_axis_rc_tvalid_a), 128'h1);
      chk("fr_tdata_a", bus.m_axis_rc_tdata_a, {4{32'h3000 + k}});
    end
    tvalid = 1'b0;
    step();
    exp_pkt++;
    chk("fr_drained", 128'(bus.m_axis_rc_tvalid_a), 128'h0);
    chk("fr_pkt", 128'(pkt), 128'(exp_pkt));
    sent = 0; rcv = 0; nb = 8; base = 32'h2000;
    tready_a = 1'b0;
    repeat (6) cyc();
    chk("full_accepted", 128'(sent), 128'd4);
    chk("full_tready", 128'(bus.m_axis_rc_tready), 128'h0);
    tready_a = 1'b1;
    cyc();
    tready_a = 1'b0;
    chk("full_pop_nopush", 128'(sent), 128'd4);
    chk("full_pop_rcv", 128'(rcv), 128'd1);
    chk("full_freed", 128'(bus.m_axis_rc_tready), 128'hF);
    tready_a = 1'b1;
    repeat (2) cyc();
    chk("pp_tready", 128'(bus.m_axis_rc_tready), 128'hF);
    chk("pp_sent", 128'(sent), 128'd6);
    chk("pp_rcv", 128'(rcv), 128'd3);
    chk("pp_tvalid_a", 128'(bus.m_axis_rc_tvalid_a), 128'h1);
    for (int c = 0; c < 40 && rcv < nb; c++) cyc();
    tvalid = 1'b0;
    chk("pp_received", 128'(rcv), 128'd8);
    chk("pp_pkt", 128'(pkt), 128'(exp_pkt));
    tready_a = 1'b0;
    tvalid = 1'b1;
    tlast = 1'b0;
    tuser = 75'(1) << 42;
    step();
    chk("disc_err", 128'(err), 128'h1);
    tuser = '0;
    repeat (2) step();
    tvalid = 1'b0;
    chk("disc_sticky", 128'(err), 128'h1);
    chk("disc_buffered", 128'(bus.m_axis_rc_tvalid_a), 128'h1);
    rst_n = 1'b0;
    step();
    exp_pkt = '0;
    chk("mid_rst_tvalid_a", 128'(bus.m_axis_rc_tvalid_a), 128'h0);
    chk("mid_rst_err", 128'(err), 128'h0);
    chk("mid_rst_pkt", 128'(pkt), 128'h0);
    chk("mid_rst_tready", 128'(bus.m_axis_rc_tready), 128'h0);
    rst_n = 1'b1;
    step();
    chk("mid_rel_tready", 128'(bus.m_axis_rc_tready), 128'hF);
    chk("mid_rel_noreplay", 128'(bus.m_axis_rc_tvalid_a), 128'h0);
    tready_a = 1'b1;
    tvalid = 1'b1;
    tlast = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      tdata = 128'(k);
      step();
    end
    chk("wrap_ffff", 128'(pkt), 128'hFFFF);
    tvalid = 1'b0;
    step();
    chk("wrap_zero", 128'(pkt), 128'h0);
    chk("wrap_empty", 128'(bus.m_axis_rc_tvalid_a), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
